// File: rtl/pid_steer_ctrl.sv
// pid_steer_ctrl: PID steering controller turning a line-centroid sample into left/right PWM pulse counts.
// Five-state pipeline IDLE->ERR->TERMS->MIX->OUT with clamped integrator and line-lost detection.
module pid_steer_ctrl #(
    parameter int CW         = 16,
    parameter int TARGET     = 159,
    parameter int SPD_MAX    = 100,
    parameter int KP_NUM     = 1,
    parameter int KP_SHIFT   = 2,
    parameter int KI_NUM     = 0,
    parameter int KI_SHIFT   = 4,
    parameter int KD_NUM     = 0,
    parameter int KD_SHIFT   = 0,
    parameter int I_LIM      = 1024,
    parameter int LOST_MAX   = 8,
    parameter int BASE_PULSE = 10000,
    parameter int PULSE_STEP = 500,
    parameter int PW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [CW-1:0] centroid,
    input  logic          line_found,
    input  logic [7:0]    speed,
    input  logic          reverse,
    output logic          busy,
    output logic          pulse_valid,
    output logic [PW-1:0] pulse_L,
    output logic [PW-1:0] pulse_R,
    output logic          lost
);
    localparam int IW = $clog2(I_LIM + 1) + 2;
    localparam int AW = (CW + 12 > IW + 11) ? CW + 12 : IW + 11;
    localparam int LW = $clog2(LOST_MAX + 1);
    localparam logic signed [AW-1:0] ZERO = '0;
    localparam logic signed [AW-1:0] ILIM = AW'(I_LIM);
    localparam logic signed [AW-1:0] SMAX = AW'(SPD_MAX);
    localparam logic signed [AW-1:0] KP   = AW'(KP_NUM);
    localparam logic signed [AW-1:0] KI   = AW'(KI_NUM);
    localparam logic signed [AW-1:0] KD   = AW'(KD_NUM);
    localparam logic signed [CW:0]   TGT  = (CW + 1)'(TARGET);
    localparam logic [LW-1:0]        LMAX = LW'(LOST_MAX);

    if (BASE_PULSE + PULSE_STEP * SPD_MAX >= 2 ** PW) begin : g_pw_check
        $error("pulse range exceeds PW bits");
    end

    typedef enum logic [2:0] {IDLE, ERR, TERMS, MIX, OUT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]         c_lat;
    logic                  f_lat, rev_lat, prev_ok;
    logic [7:0]            spd_lat, s_min, sl_c, sr_c, fin_l, fin_r;
    logic signed [CW:0]    e, e_prev, e_new;
    logic signed [AW-1:0]  e_x, ep_x, i_acc, i_sum, i_clp, i_nxt;
    logic signed [AW-1:0]  p_t, i_t, d_raw, d_t, adj, s_x, sl_w, sr_w;
    logic [LW-1:0]         lost_cnt, lost_inc;

    always_comb begin
        state_nxt = (state == IDLE)  ? (sample_valid ? ERR : IDLE) :
                    (state == ERR)   ? TERMS :
                    (state == TERMS) ? MIX :
                    (state == MIX)   ? OUT : IDLE;
    end

    assign busy        = (state != IDLE);
    assign pulse_valid = (state == OUT);

    // Sign-extend errors by hand so every downstream operand stays signed.
    assign e_new    = $signed({1'b0, c_lat}) - TGT;
    assign e_x      = {{(AW-CW-1){e[CW]}}, e};
    assign ep_x     = {{(AW-CW-1){e_prev[CW]}}, e_prev};
    assign lost_inc = (lost_cnt == LMAX) ? LMAX : lost_cnt + 1'b1;

    always_comb begin
        i_sum = i_acc + e_x;
        i_clp = (i_sum > ILIM) ? ILIM : ((i_sum < -ILIM) ? -ILIM : i_sum);
        i_nxt = lost ? ZERO : (f_lat ? i_clp : i_acc);
        p_t   = (e_x * KP) >>> KP_SHIFT;
        i_t   = (i_nxt * KI) >>> KI_SHIFT;
        d_raw = ((e_x - ep_x) * KD) >>> KD_SHIFT;
        d_t   = prev_ok ? d_raw : ZERO;
        s_min = (spd_lat > 8'(SPD_MAX)) ? 8'(SPD_MAX) : spd_lat;
        s_x   = {{(AW-8){1'b0}}, s_min};
        sl_w  = s_x + adj;
        sr_w  = s_x - adj;
        sl_c  = (sl_w < ZERO) ? 8'd0 : ((sl_w > SMAX) ? 8'(SPD_MAX) : sl_w[7:0]);
        sr_c  = (sr_w < ZERO) ? 8'd0 : ((sr_w > SMAX) ? 8'(SPD_MAX) : sr_w[7:0]);
        fin_l = lost ? 8'd0 : (rev_lat ? sr_c : sl_c);
        fin_r = lost ? 8'd0 : (rev_lat ? sl_c : sr_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            c_lat    <= '0;
            f_lat    <= 1'b0;
            spd_lat  <= '0;
            rev_lat  <= 1'b0;
            e        <= '0;
            e_prev   <= '0;
            prev_ok  <= 1'b0;
            i_acc    <= '0;
            adj      <= '0;
            lost_cnt <= '0;
            lost     <= 1'b0;
            pulse_L  <= PW'(BASE_PULSE);
            pulse_R  <= PW'(BASE_PULSE);
        end else begin
            state <= state_nxt;
            if (state == IDLE && sample_valid) begin
                c_lat   <= centroid;
                f_lat   <= line_found;
                spd_lat <= speed;
                rev_lat <= reverse;
            end
            if (state == ERR) begin
                e        <= f_lat ? e_new : e_prev;
                lost_cnt <= f_lat ? '0 : lost_inc;
                lost     <= f_lat ? 1'b0 : (lost_inc == LMAX);
            end
            if (state == TERMS) begin
                i_acc <= i_nxt;
                adj   <= p_t + i_t + d_t;
                if (f_lat) begin
                    e_prev  <= e;
                    prev_ok <= 1'b1;
                end
            end
            if (state == MIX) begin
                pulse_L <= PW'(BASE_PULSE) + PW'(PULSE_STEP) * PW'(fin_l);
                pulse_R <= PW'(BASE_PULSE) + PW'(PULSE_STEP) * PW'(fin_r);
            end
        end
    end
endmodule
